// File: rtl/avr_fetch_unit_if.sv
// Fetch-unit bus: program-memory read port plus the instruction port into the core.
// A transfer happens on a cycle where the producer's valid and the consumer's ready are both 1.
interface avr_fetch_unit_if #(
    parameter int PC_WIDTH = 16
);
    logic                pm_req;
    logic [PC_WIDTH-1:0] pm_addr;
    logic                pm_valid;
    logic [15:0]         pm_data;
    logic [15:0]         instr;
    logic [15:0]         instr_k;
    logic [PC_WIDTH-1:0] instr_pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic                instr_valid;
    logic                instr_ready;
    logic                skip;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;

    modport master (
        output pm_req, pm_addr,
        input  pm_valid, pm_data,
        output instr, instr_k, instr_pc, pc_next, instr_valid,
        input  instr_ready, skip, redirect, redirect_pc
    );

    modport slave (
        input  pm_req, pm_addr,
        output pm_valid, pm_data,
        input  instr, instr_k, instr_pc, pc_next, instr_valid,
        output instr_ready, skip, redirect, redirect_pc
    );
endinterface

// File: rtl/avr_fetch_unit.sv
// AVR instruction fetch sequencer: owns the PC, reads one or two program words per
// instruction, presents them to the core and applies redirects and skips.
module avr_fetch_unit #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic               CLK,
    input  logic               RST,
    avr_fetch_unit_if.master   bus,
    output logic [1:0]         o_dbg_state
);
    typedef enum logic [1:0] {
        S_FETCH1 = 2'd0,
        S_FETCH2 = 2'd1,
        S_ISSUE  = 2'd2
    } state_t;

    state_t              r_state, w_state_d;
    logic [PC_WIDTH-1:0] r_pc, w_pc_d;
    logic [PC_WIDTH-1:0] r_redir_pc, w_redir_pc_d;
    logic [PC_WIDTH-1:0] r_instr_pc, w_instr_pc_d;
    logic [PC_WIDTH-1:0] r_pc_after, w_pc_after_d;
    logic [15:0]         r_instr, w_instr_d;
    logic [15:0]         r_instr_k, w_instr_k_d;
    logic                r_skip_pending, w_skip_pending_d;
    logic                r_drop_pending, w_drop_pending_d;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic                w_two_word;

    assign w_pc_inc   = r_pc + PC_WIDTH'(1);
    // LDS/STS and JMP/CALL carry a second word (address or constant).
    assign w_two_word = ((bus.pm_data & 16'hFC0F) == 16'h9000) ||
                        ((bus.pm_data & 16'hFE0C) == 16'h940C);

    always_comb begin
        w_state_d        = r_state;
        w_pc_d           = r_pc;
        w_redir_pc_d     = r_redir_pc;
        w_instr_pc_d     = r_instr_pc;
        w_pc_after_d     = r_pc_after;
        w_instr_d        = r_instr;
        w_instr_k_d      = r_instr_k;
        w_skip_pending_d = r_skip_pending;
        w_drop_pending_d = r_drop_pending;
        case (r_state)
            S_FETCH1, S_FETCH2: begin
                if (bus.redirect) begin
                    w_skip_pending_d = 1'b0;
                    if (bus.pm_valid) begin
                        w_pc_d           = bus.redirect_pc;
                        w_state_d        = S_FETCH1;
                        w_drop_pending_d = 1'b0;
                    end else begin
                        // Address must hold until the memory answers; that answer is thrown away.
                        w_drop_pending_d = 1'b1;
                        w_redir_pc_d     = bus.redirect_pc;
                    end
                end else if (bus.pm_valid) begin
                    if (r_drop_pending) begin
                        w_pc_d           = r_redir_pc;
                        w_state_d        = S_FETCH1;
                        w_drop_pending_d = 1'b0;
                    end else if (r_state == S_FETCH1) begin
                        w_pc_d = w_pc_inc;
                        if (!r_skip_pending) begin
                            w_instr_d    = bus.pm_data;
                            w_instr_pc_d = r_pc;
                        end
                        if (w_two_word) begin
                            w_state_d = S_FETCH2;
                        end else if (r_skip_pending) begin
                            w_skip_pending_d = 1'b0;
                            w_state_d        = S_FETCH1;
                        end else begin
                            w_instr_k_d  = '0;
                            w_pc_after_d = w_pc_inc;
                            w_state_d    = S_ISSUE;
                        end
                    end else begin
                        w_pc_d = w_pc_inc;
                        if (r_skip_pending) begin
                            w_skip_pending_d = 1'b0;
                            w_state_d        = S_FETCH1;
                        end else begin
                            w_instr_k_d  = bus.pm_data;
                            w_pc_after_d = w_pc_inc;
                            w_state_d    = S_ISSUE;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (bus.redirect) begin
                    w_pc_d           = bus.redirect_pc;
                    w_skip_pending_d = 1'b0;
                    w_state_d        = S_FETCH1;
                end else if (bus.instr_ready) begin
                    w_skip_pending_d = bus.skip;
                    w_state_d        = S_FETCH1;
                end
            end
            default: begin
                w_state_d = S_FETCH1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= S_FETCH1;
            r_pc           <= RESET_VECTOR;
            r_redir_pc     <= '0;
            r_instr_pc     <= '0;
            r_pc_after     <= '0;
            r_instr        <= '0;
            r_instr_k      <= '0;
            r_skip_pending <= 1'b0;
            r_drop_pending <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_pc           <= w_pc_d;
            r_redir_pc     <= w_redir_pc_d;
            r_instr_pc     <= w_instr_pc_d;
            r_pc_after     <= w_pc_after_d;
            r_instr        <= w_instr_d;
            r_instr_k      <= w_instr_k_d;
            r_skip_pending <= w_skip_pending_d;
            r_drop_pending <= w_drop_pending_d;
        end
    end

    // Request is held off while reset is applied so it first rises in the cycle RST drops.
    assign bus.pm_req      = !RST && (r_state != S_ISSUE);
    assign bus.pm_addr     = r_pc;
    assign bus.instr_valid = (r_state == S_ISSUE);
    assign bus.instr       = r_instr;
    assign bus.instr_k     = r_instr_k;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.pc_next     = r_pc_after;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_avr_fetch_unit.sv
// Bench for avr_fetch_unit (8-bit PC): program-order reference model feeds an expected
// queue; a monitor pops it on every instruction handshake.
module tb_avr_fetch_unit;
    localparam int            PW = 8;
    localparam logic [PW-1:0] RV = '0;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] dbg_state;

    avr_fetch_unit_if #(.PC_WIDTH(PW)) bus ();

    avr_fetch_unit #(.PC_WIDTH(PW), .RESET_VECTOR(RV)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus.master),
        .o_dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    // Program memory with a programmable number of wait cycles before pm_valid.
    logic [15:0] mem [256];
    int          mem_lat = 0;
    int          wait_cnt = 0;
    assign bus.pm_valid = bus.pm_req && (wait_cnt >= mem_lat);
    assign bus.pm_data  = mem[bus.pm_addr];
    always @(posedge CLK) begin
        if (RST || !bus.pm_req || bus.pm_valid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    int            total = 0;
    int            bad = 0;
    int            hs_count = 0;
    logic [47:0]   exp_q[$];
    logic [PW-1:0] fetch_log[$];
    logic [PW-1:0] last_next;
    bit            skip_armed;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: the instruction at address a as {word, second word, pc, following pc}.
    function automatic logic [47:0] make_exp(input logic [PW-1:0] a);
        logic [15:0]   w;
        logic [15:0]   k;
        logic [PW-1:0] a1;
        logic [PW-1:0] a2;
        logic          two;
        w   = mem[a];
        a1  = a + PW'(1);
        a2  = a + PW'(2);
        two = ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
        k   = two ? mem[a1] : 16'h0000;
        return {w, k, a, two ? a2 : a1};
    endfunction

    function automatic logic [47:0] cur_out();
        return {bus.instr, bus.instr_k, bus.instr_pc, bus.pc_next};
    endfunction

    function automatic logic [PW-1:0] log_at(input int i);
        return (i < fetch_log.size()) ? fetch_log[i] : '1;
    endfunction

    function automatic logic [15:0] rand_word();
        int          r;
        logic [15:0] v;
        r = $urandom_range(0, 7);
        v = 16'($urandom);
        case (r)
            0:       return 16'h9000 | (v & 16'h03F0);
            1:       return 16'h940C | (v & 16'h01F3);
            default: return v;
        endcase
    endfunction

    task automatic push_exp(input logic [PW-1:0] a);
        logic [47:0] e;
        e = make_exp(a);
        exp_q.push_back(e);
        last_next = e[7:0];
    endtask

    // Model update for what the core drives this cycle.
    task automatic model_step(input logic rdy, input logic sk, input logic rd, input logic [PW-1:0] tgt);
        logic [PW-1:0] a;
        if (bus.instr_valid) skip_armed = 1'b0;
        if (rd) begin
            if (bus.instr_valid) begin
                if (!rdy && exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (exp_q.size() > 0) begin
                void'(exp_q.pop_back());
            end
            push_exp(tgt);
            skip_armed = 1'b0;
        end else if (bus.instr_valid && rdy) begin
            a = last_next;
            if (sk) a = make_exp(a)[7:0];
            push_exp(a);
            skip_armed = sk;
        end
    endtask

    task automatic core_cycle(input logic rdy, input logic sk, input logic rd, input logic [PW-1:0] tgt);
        bus.instr_ready = rdy;
        bus.skip        = sk;
        bus.redirect    = rd;
        bus.redirect_pc = tgt;
        model_step(rdy, sk, rd, tgt);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_until_valid(input int max, input string name);
        int n;
        n = 0;
        while (!bus.instr_valid && n < max) begin
            core_cycle(1'b0, 1'b0, 1'b0, '0);
            n++;
        end
        chk(name, bus.instr_valid, 1'b1);
    endtask

    task automatic do_reset();
        RST             = 1'b1;
        bus.instr_ready = 1'b0;
        bus.skip        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        @(posedge CLK);
        #1;
        chk("rst_pm_req", bus.pm_req, 1'b0);
        chk("rst_instr_valid", bus.instr_valid, 1'b0);
        chk("rst_outputs", cur_out(), 48'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        skip_armed = 1'b0;
        push_exp(RV);
        #1;
        chk("first_fetch_req", bus.pm_req, 1'b1);
        chk("first_fetch_addr", bus.pm_addr, RV);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every handshake.
    initial begin
        logic          prev_wait;
        logic [PW-1:0] prev_addr;
        logic          prev_hold;
        logic [47:0]   prev_out;
        logic [47:0]   e;
        int            idle_cnt;
        prev_wait = 1'b0;
        prev_hold = 1'b0;
        prev_addr = '0;
        prev_out  = '0;
        idle_cnt  = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_wait = 1'b0;
                prev_hold = 1'b0;
                idle_cnt  = 0;
            end else begin
                chk("valid_req_excl", bus.instr_valid & bus.pm_req, 1'b0);
                if (prev_wait) begin
                    chk("addr_hold_req", bus.pm_req, 1'b1);
                    chk("addr_hold", bus.pm_addr, prev_addr);
                end
                if (prev_hold) begin
                    chk("stall_valid", bus.instr_valid, 1'b1);
                    chk("stall_outputs", cur_out(), prev_out);
                end
                if (bus.pm_req && bus.pm_valid) fetch_log.push_back(bus.pm_addr);
                if (bus.instr_valid && bus.instr_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_instr: got=%0h expected=none", cur_out());
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr_fields", cur_out(), e);
                    end
                end
                idle_cnt = bus.instr_valid ? 0 : idle_cnt + 1;
                if (idle_cnt > 40) begin
                    total++;
                    bad++;
                    $display("FAIL watchdog_idle: got=%0d idle cycles expected<=40", idle_cnt);
                    idle_cnt = 0;
                end
                prev_wait = bus.pm_req && !bus.pm_valid;
                prev_addr = bus.pm_addr;
                prev_hold = bus.instr_valid && !bus.instr_ready && !bus.redirect;
                prev_out  = cur_out();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [47:0]   snap;
        logic          rdy, sk, rd;
        logic [PW-1:0] tgt;
        int            n;
        int            hs0;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h50A1;
        mem[1]    = 16'h50A2;
        mem[4]    = 16'h9000;
        mem[5]    = 16'h0123;
        mem[6]    = 16'h5006;
        mem[7]    = 16'h5007;
        mem[10]   = 16'h500A;
        mem[11]   = 16'h940C;
        mem[12]   = 16'h0040;
        mem[13]   = 16'h500D;
        mem[8'h40] = 16'h5040;
        mem[8'hFF] = 16'h9200;
        mem_lat = 0;

        // Reset, first two one-word instructions at full rate.
        do_reset();
        chk("first_issue_latency", bus.instr_valid, 1'b1);
        core_cycle(1'b1, 1'b0, 1'b0, '0);
        chk("second_fetch_valid", bus.instr_valid, 1'b0);
        chk("second_fetch_addr", bus.pm_addr, 8'd1);
        core_cycle(1'b1, 1'b0, 1'b0, '0);
        chk("second_issue_valid", bus.instr_valid, 1'b1);
        chk("second_issue_pc", bus.instr_pc, 8'd1);

        // Two-word LDS reached through a redirect.
        core_cycle(1'b1, 1'b0, 1'b1, 8'd4);
        fetch_log.delete();
        run_until_valid(10, "lds_valid");
        chk("lds_fetch_cnt", fetch_log.size(), 2);
        chk("lds_fetch0", log_at(0), 8'd4);
        chk("lds_fetch1", log_at(1), 8'd5);
        core_cycle(1'b1, 1'b0, 1'b0, '0);
        fetch_log.delete();
        run_until_valid(10, "after_lds_valid");
        chk("after_lds_fetch", log_at(0), 8'd6);

        // Core stalls for five cycles.
        snap = cur_out();
        for (int i = 0; i < 5; i++) begin
            core_cycle(1'b0, 1'b0, 1'b0, '0);
            chk("stall_hold_out", cur_out(), snap);
            chk("stall_no_req", bus.pm_req, 1'b0);
        end
        core_cycle(1'b1, 1'b0, 1'b0, '0);
        fetch_log.delete();
        run_until_valid(10, "after_stall_valid");
        chk("after_stall_fetch", log_at(0), 8'd7);

        // Skip over a two-word JMP at 11.
        core_cycle(1'b1, 1'b0, 1'b1, 8'd10);
        run_until_valid(10, "pre_skip_valid");
        core_cycle(1'b1, 1'b1, 1'b0, '0);
        fetch_log.delete();
        run_until_valid(12, "post_skip_valid");
        chk("skip_fetch_cnt", fetch_log.size(), 3);
        chk("skip_fetch0", log_at(0), 8'd11);
        chk("skip_fetch1", log_at(1), 8'd12);
        chk("skip_issue_pc", bus.instr_pc, 8'd13);

        // Redirect during the second wait cycle of a slow fetch at 7.
        mem_lat = 3;
        core_cycle(1'b1, 1'b0, 1'b1, 8'd7);
        fetch_log.delete();
        core_cycle(1'b0, 1'b0, 1'b0, '0);
        core_cycle(1'b0, 1'b0, 1'b1, 8'h40);
        chk("drop_addr_hold", bus.pm_addr, 8'd7);
        run_until_valid(30, "drop_valid");
        chk("drop_fetch_cnt", fetch_log.size(), 2);
        chk("drop_fetch0", log_at(0), 8'd7);
        chk("drop_fetch1", log_at(1), 8'h40);
        chk("drop_issue_pc", bus.instr_pc, 8'h40);

        // Two-word instruction at the top address wraps to 0 for its second word.
        mem_lat = 0;
        mem[0] = 16'h0055;
        core_cycle(1'b1, 1'b0, 1'b1, 8'hFF);
        run_until_valid(10, "wrap_valid");
        chk("wrap_pc", bus.instr_pc, 8'hFF);
        chk("wrap_k", bus.instr_k, 16'h0055);
        chk("wrap_pc_next", bus.pc_next, 8'h01);

        // Reset in the middle of the second-word fetch.
        mem_lat = 2;
        core_cycle(1'b1, 1'b0, 1'b1, 8'hFF);
        n = 0;
        while (!(bus.pm_req && bus.pm_addr == 8'h00) && n < 20) begin
            core_cycle(1'b0, 1'b0, 1'b0, '0);
            n++;
        end
        chk("reach_fetch2", bus.pm_req && (bus.pm_addr == 8'h00), 1'b1);
        do_reset();
        run_until_valid(10, "refetch_valid");
        chk("refetch_pc", bus.instr_pc, RV);
        chk("refetch_instr", bus.instr, 16'h0055);
        core_cycle(1'b1, 1'b0, 1'b0, '0);

        // Randomized program, memory latency and core behaviour.
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
        mem_lat = 0;
        do_reset();
        hs0 = hs_count;
        for (int c = 0; c < 4000; c++) begin
            if (c % 16 == 0) mem_lat = $urandom_range(0, 2);
            rdy = ($urandom_range(0, 3) != 0);
            sk  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 15) == 0) && (bus.instr_valid || !skip_armed);
            tgt = PW'($urandom);
            core_cycle(rdy, sk, rd, tgt);
        end
        chk("random_progress", (hs_count - hs0) > 200, 1'b1);
        chk("queue_depth", exp_q.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
